banco_registradores_param: RTL and testbench
============================================

# banco_registradores_param

Parametrised general-purpose register file with configurable width, depth and read-port count, plus a pending-write scoreboard for hazard detection. Sits in the decode/writeback path of the datapath: read ports feed operand fetch, the write port takes writeback results, and the reservation port marks destinations of in-flight instructions. Register 0 reads as zero and is never written or reserved.

## Interface
- LARGURA, 32, data width in bits (≥ 8)
- NUM_REG, 32, number of registers (power of two, 4–64)
- NUM_LEIT, 2, number of read ports (1–4)
- END (derived, not overridable), $clog2(NUM_REG), address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- origem  in  NUM_LEIT*END  read addresses; port k at bits [k*END +: END]
- dado_saida  out  NUM_LEIT*LARGURA  read data; port k at [k*LARGURA +: LARGURA]
- pendente  out  NUM_LEIT  port k's source register has an outstanding reservation
- escrita  in  1  write enable
- destino  in  END  write address
- dado_entrada  in  LARGURA  write data
- reserva  in  1  reservation request
- reserva_destino  in  END  register to mark pending
- contador_pendentes  out  END+1  number of registers currently pending

## Operation
- Reset (rst_n low, asynchronous): all registers ← 0, all scoreboard bits ← 0, contador_pendentes ← 0; dado_saida reads 0, pendente = 0.
- Read: combinational; dado_saida[k] = banco[origem[k]], forced 0 when origem[k] = 0.
- Write: at posedge, if escrita and destino ≠ 0, banco[destino] ← dado_entrada. destino = 0 is ignored.
- Scoreboard: escrita clears bit[destino]; reserva sets bit[reserva_destino]; address 0 is ignored for both.
- Same register in the same cycle: reserva wins; bit remains/becomes 1 (new producer supersedes completing one); data is still written.
- Write to a non-pending register: data written, bit stays 0, counter unchanged.
- Reserve of an already-pending register: bit stays 1, counter unchanged.
- contador_pendentes: registered; after each edge equals the popcount of the scoreboard. Net change per cycle is −1, 0 or +1. Maximum NUM_REG−1.
- pendente[k] = bit[origem[k]] (0 for origem 0), modified by bypass below.

## Timing
- Read latency 0 cycles (combinational from origem and state).
- Write visible on reads the cycle after the edge (without bypass).
- Reservation visible on pendente the cycle after the edge.
- Clear on writeback visible the cycle after the edge (without bypass).
- Reset deassertion: first write accepted at the first rising edge with rst_n high.
- Reset asserted mid-operation discards all data and reservations immediately.

## Configuration
- BANCO_BYPASS_EN defined: if escrita and destino = origem[k] ≠ 0, dado_saida[k] = dado_entrada and pendente[k] = 0 in the same cycle. A same-cycle reserva of that register does not raise pendente until the next cycle.
- Undefined: reads return stored contents; pendente follows registered scoreboard bits only; 1-cycle write-to-read latency.

## Structure
- Shared package banco_pkg: default LARGURA/NUM_REG/NUM_LEIT constants, END derivation function, REG_ZERO address constant.
- Sub-module placar_registradores: scoreboard bits, set/clear priority, popcount counter. Parameters NUM_REG. Instantiated once.
- Storage array and read muxes live in the top module.

## Test plan
- Reset with rst_n low mid-run after writes → all dado_saida 0, pendente 0, contador_pendentes 0 immediately, without waiting for a clock edge.
- Write 0xDEADBEEF to r5, then read r5 on port 1 next cycle → 0xDEADBEEF; write to r0 → r0 still reads 0.
- Reserve r7, then r9 → pendente set on reads of r7 and r9, counter 2; writeback r7 → counter 1, r7 not pending.
- Reserve r4 and write r4 in the same cycle → r4 pending, data updated, counter +1.
- BANCO_BYPASS_EN: write 0x1234 to r3 while reading r3 → dado_saida 0x1234 and pendente 0 in the same cycle. Without the macro → old value in that cycle, 0x1234 in the next.
- Non-default parameters LARGURA=16, NUM_REG=8, NUM_LEIT=4: all four ports read distinct registers correctly; reserving r1–r7 → counter 7.

Source files
------------

// File: rtl/banco_pkg.sv
`default_nettype none
// ============================================================================
// Module      : banco_pkg
// Description : Shared defaults, address-width helper and the zero-register
//               address for the parametrised register file.
// Revision    : 1.0 - initial release
// ============================================================================
package banco_pkg;

    localparam int LARGURA_PADRAO  = 32;
    localparam int NUM_REG_PADRAO  = 32;
    localparam int NUM_LEIT_PADRAO = 2;
    localparam int REG_ZERO        = 0;

    function automatic int calc_end(input int num_reg);
        return $clog2(num_reg);
    endfunction

endpackage : banco_pkg
`default_nettype wire

// File: rtl/placar_registradores.sv
`default_nettype none
// ============================================================================
// Module      : placar_registradores
// Description : Pending-write scoreboard with reserve-over-clear priority and
//               a registered popcount of outstanding reservations.
// Revision    : 1.0 - initial release
// ============================================================================
module placar_registradores
    import banco_pkg::*;
#(
    parameter int NUM_REG = NUM_REG_PADRAO,
    localparam int END    = calc_end(NUM_REG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               escrita,
    input  logic [END-1:0]     destino,
    input  logic               reserva,
    input  logic [END-1:0]     reserva_destino,
    output logic [NUM_REG-1:0] placar,
    output logic [END:0]       contador_pendentes
);

    logic [NUM_REG-1:0] placar_q;
    logic [NUM_REG-1:0] placar_d;
    logic [END:0]       contador_q;
    logic [END:0]       contador_d;

    // The reservation is applied last so a new producer supersedes a
    // completing one on the same register.
    always_comb begin
        placar_d = placar_q;
        if (escrita && (destino != END'(REG_ZERO)))
            placar_d[destino] = 1'b0;
        if (reserva && (reserva_destino != END'(REG_ZERO)))
            placar_d[reserva_destino] = 1'b1;
        placar_d[0] = 1'b0;
    end

    always_comb begin
        contador_d = '0;
        for (int i = 1; i < NUM_REG; i++)
            contador_d = contador_d + {{END{1'b0}}, placar_d[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            placar_q   <= '0;
            contador_q <= '0;
        end else begin
            placar_q   <= placar_d;
            contador_q <= contador_d;
        end
    end

    assign placar             = placar_q;
    assign contador_pendentes = contador_q;

endmodule : placar_registradores
`default_nettype wire

// File: rtl/banco_registradores_param.sv
`default_nettype none
// ============================================================================
// Module      : banco_registradores_param
// Description : Parametrised register file, multi-port combinational reads,
//               r0 hard-wired to zero, pending-write scoreboard.
//               Optional write-to-read bypass: BANCO_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module banco_registradores_param
    import banco_pkg::*;
#(
    parameter int LARGURA  = LARGURA_PADRAO,
    parameter int NUM_REG  = NUM_REG_PADRAO,
    parameter int NUM_LEIT = NUM_LEIT_PADRAO,
    localparam int END     = calc_end(NUM_REG)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_LEIT*END-1:0]     origem,
    output logic [NUM_LEIT*LARGURA-1:0] dado_saida,
    output logic [NUM_LEIT-1:0]         pendente,
    input  logic                        escrita,
    input  logic [END-1:0]              destino,
    input  logic [LARGURA-1:0]          dado_entrada,
    input  logic                        reserva,
    input  logic [END-1:0]              reserva_destino,
    output logic [END:0]                contador_pendentes
);

    logic [LARGURA-1:0] banco_q [NUM_REG];
    logic [NUM_REG-1:0] placar;

    // Entry 0 is reset and never written, so it always holds zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REG; i++)
                banco_q[i] <= '0;
        end else if (escrita && (destino != END'(REG_ZERO))) begin
            banco_q[destino] <= dado_entrada;
        end
    end

    placar_registradores #(
        .NUM_REG (NUM_REG)
    ) u_placar (
        .clk                (clk),
        .rst_n              (rst_n),
        .escrita            (escrita),
        .destino            (destino),
        .reserva            (reserva),
        .reserva_destino    (reserva_destino),
        .placar             (placar),
        .contador_pendentes (contador_pendentes)
    );

    for (genvar k = 0; k < NUM_LEIT; k++) begin : g_leitura
        logic [END-1:0] end_k;
        logic           ler_zero;

        assign end_k    = origem[k*END +: END];
        assign ler_zero = (end_k == END'(REG_ZERO));

`ifdef BANCO_BYPASS_EN
        logic bypass;
        assign bypass = escrita && !ler_zero && (destino == end_k);

        assign dado_saida[k*LARGURA +: LARGURA] = ler_zero ? '0 :
                                                  bypass   ? dado_entrada :
                                                             banco_q[end_k];
        assign pendente[k] = !ler_zero && !bypass && placar[end_k];
`else
        assign dado_saida[k*LARGURA +: LARGURA] = ler_zero ? '0 : banco_q[end_k];
        assign pendente[k] = !ler_zero && placar[end_k];
`endif
    end

endmodule : banco_registradores_param
`default_nettype wire

// File: tb/tb_banco_registradores_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_banco_registradores_param
// Description : Directed self-checking bench for the default and a reduced
//               (16-bit, 8-register, 4-port) configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banco_registradores_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [9:0]  origem = '0;
    logic [63:0] dado_saida;
    logic [1:0]  pendente;
    logic        escrita = 1'b0;
    logic [4:0]  destino = '0;
    logic [31:0] dado_entrada = '0;
    logic        reserva = 1'b0;
    logic [4:0]  reserva_destino = '0;
    logic [5:0]  contador;

    logic [11:0] origem2 = '0;
    logic [63:0] dado_saida2;
    logic [3:0]  pendente2;
    logic        escrita2 = 1'b0;
    logic [2:0]  destino2 = '0;
    logic [15:0] dado_entrada2 = '0;
    logic        reserva2 = 1'b0;
    logic [2:0]  reserva_destino2 = '0;
    logic [3:0]  contador2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    banco_registradores_param dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .origem             (origem),
        .dado_saida         (dado_saida),
        .pendente           (pendente),
        .escrita            (escrita),
        .destino            (destino),
        .dado_entrada       (dado_entrada),
        .reserva            (reserva),
        .reserva_destino    (reserva_destino),
        .contador_pendentes (contador)
    );

    banco_registradores_param #(
        .LARGURA  (16),
        .NUM_REG  (8),
        .NUM_LEIT (4)
    ) dut2 (
        .clk                (clk),
        .rst_n              (rst_n),
        .origem             (origem2),
        .dado_saida         (dado_saida2),
        .pendente           (pendente2),
        .escrita            (escrita2),
        .destino            (destino2),
        .dado_entrada       (dado_entrada2),
        .reserva            (reserva2),
        .reserva_destino    (reserva_destino2),
        .contador_pendentes (contador2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        origem = {5'd3, 5'd1};
        #1;
        n_cmp++;
        if (dado_saida !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_dado: got %h expected %h", dado_saida, 64'h0);
        end
        n_cmp++;
        if (pendente !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_pendente: got %b expected %b", pendente, 2'b00);
        end
        n_cmp++;
        if (contador !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_contador: got %0d expected %0d", contador, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        escrita = 1'b1; destino = 5'd5; dado_entrada = 32'hDEADBEEF;
        tick();
        escrita = 1'b0;
        origem = {5'd5, 5'd0};
        #1;
        n_cmp++;
        if (dado_saida[63:32] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_r5: got %h expected %h", dado_saida[63:32], 32'hDEADBEEF);
        end
        n_cmp++;
        if (pendente !== 2'b00 || contador !== 6'd0) begin
            n_fail++;
            $display("FAIL write_nonpending: got pend=%b cnt=%0d expected pend=00 cnt=0", pendente, contador);
        end
        escrita = 1'b1; destino = 5'd0; dado_entrada = 32'h11111111;
        tick();
        escrita = 1'b0;
        #1;
        n_cmp++;
        if (dado_saida[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL write_r0: got %h expected %h", dado_saida[31:0], 32'h0);
        end
    endtask

    task automatic test_reserve();
        reserva = 1'b1; reserva_destino = 5'd7;
        tick();
        reserva_destino = 5'd9;
        tick();
        reserva = 1'b0;
        origem = {5'd9, 5'd7};
        #1;
        n_cmp++;
        if (pendente !== 2'b11) begin
            n_fail++;
            $display("FAIL reserve_pend: got %b expected %b", pendente, 2'b11);
        end
        n_cmp++;
        if (contador !== 6'd2) begin
            n_fail++;
            $display("FAIL reserve_cnt: got %0d expected %0d", contador, 2);
        end
        origem = {5'd9, 5'd0};
        escrita = 1'b1; destino = 5'd7; dado_entrada = 32'h0000AAAA;
        tick();
        escrita = 1'b0;
        origem = {5'd9, 5'd7};
        #1;
        n_cmp++;
        if (contador !== 6'd1 || pendente !== 2'b10) begin
            n_fail++;
            $display("FAIL writeback_clear: got cnt=%0d pend=%b expected cnt=1 pend=10", contador, pendente);
        end
        n_cmp++;
        if (dado_saida[31:0] !== 32'h0000AAAA) begin
            n_fail++;
            $display("FAIL writeback_data: got %h expected %h", dado_saida[31:0], 32'h0000AAAA);
        end
    endtask

    task automatic test_same_cycle();
        reserva = 1'b1; reserva_destino = 5'd4;
        escrita = 1'b1; destino = 5'd4; dado_entrada = 32'h00000044;
        origem = {5'd9, 5'd0};
        tick();
        reserva = 1'b0; escrita = 1'b0;
        origem = {5'd9, 5'd4};
        #1;
        n_cmp++;
        if (pendente !== 2'b11) begin
            n_fail++;
            $display("FAIL same_pend: got %b expected %b", pendente, 2'b11);
        end
        n_cmp++;
        if (dado_saida[31:0] !== 32'h00000044) begin
            n_fail++;
            $display("FAIL same_data: got %h expected %h", dado_saida[31:0], 32'h00000044);
        end
        n_cmp++;
        if (contador !== 6'd2) begin
            n_fail++;
            $display("FAIL same_cnt: got %0d expected %0d", contador, 2);
        end
    endtask

    task automatic test_bypass();
        escrita = 1'b1; destino = 5'd3; dado_entrada = 32'h00005555;
        origem = {5'd0, 5'd0};
        tick();
        escrita = 1'b0;
        #1;
        origem = {5'd0, 5'd3};
        escrita = 1'b1; destino = 5'd3; dado_entrada = 32'h00001234;
        reserva = 1'b1; reserva_destino = 5'd3;
        #1;
`ifdef BANCO_BYPASS_EN
        n_cmp++;
        if (dado_saida[31:0] !== 32'h00001234) begin
            n_fail++;
            $display("FAIL bypass_data: got %h expected %h", dado_saida[31:0], 32'h00001234);
        end
`else
        n_cmp++;
        if (dado_saida[31:0] !== 32'h00005555) begin
            n_fail++;
            $display("FAIL nobypass_data: got %h expected %h", dado_saida[31:0], 32'h00005555);
        end
`endif
        n_cmp++;
        if (pendente[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_pend_same: got %b expected %b", pendente[0], 1'b0);
        end
        tick();
        escrita = 1'b0; reserva = 1'b0;
        #1;
        n_cmp++;
        if (dado_saida[31:0] !== 32'h00001234 || pendente[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_next: got data=%h pend=%b expected data=00001234 pend=1", dado_saida[31:0], pendente[0]);
        end
        n_cmp++;
        if (contador !== 6'd3) begin
            n_fail++;
            $display("FAIL bypass_cnt: got %0d expected %0d", contador, 3);
        end
    endtask

    task automatic test_reset_mid();
        origem = {5'd4, 5'd5};
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dado_saida !== 64'h0 || pendente !== 2'b00 || contador !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got data=%h pend=%b cnt=%0d expected all zero", dado_saida, pendente, contador);
        end
        @(negedge clk);
        rst_n = 1'b1;
        escrita = 1'b1; destino = 5'd5; dado_entrada = 32'h00000077;
        tick();
        escrita = 1'b0;
        #1;
        n_cmp++;
        if (dado_saida[31:0] !== 32'h00000077) begin
            n_fail++;
            $display("FAIL reset_first_write: got %h expected %h", dado_saida[31:0], 32'h00000077);
        end
    endtask

    task automatic test_small_config();
        for (int i = 1; i < 8; i++) begin
            escrita2 = 1'b1; destino2 = 3'(i); dado_entrada2 = 16'h1100 + 16'(i);
            tick();
        end
        escrita2 = 1'b0;
        origem2 = {3'd7, 3'd5, 3'd3, 3'd1};
        #1;
        n_cmp++;
        if (dado_saida2 !== {16'h1107, 16'h1105, 16'h1103, 16'h1101}) begin
            n_fail++;
            $display("FAIL small_odd: got %h expected %h", dado_saida2, {16'h1107, 16'h1105, 16'h1103, 16'h1101});
        end
        origem2 = {3'd0, 3'd6, 3'd4, 3'd2};
        #1;
        n_cmp++;
        if (dado_saida2 !== {16'h0000, 16'h1106, 16'h1104, 16'h1102}) begin
            n_fail++;
            $display("FAIL small_even: got %h expected %h", dado_saida2, {16'h0000, 16'h1106, 16'h1104, 16'h1102});
        end
        for (int i = 1; i < 8; i++) begin
            reserva2 = 1'b1; reserva_destino2 = 3'(i);
            tick();
        end
        reserva_destino2 = 3'd0;
        tick();
        reserva2 = 1'b0;
        origem2 = {3'd7, 3'd5, 3'd3, 3'd1};
        #1;
        n_cmp++;
        if (contador2 !== 4'd7) begin
            n_fail++;
            $display("FAIL small_cnt: got %0d expected %0d", contador2, 7);
        end
        n_cmp++;
        if (pendente2 !== 4'b1111) begin
            n_fail++;
            $display("FAIL small_pend: got %b expected %b", pendente2, 4'b1111);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_reserve();
        test_same_cycle();
        test_bypass();
        test_reset_mid();
        test_small_config();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_banco_registradores_param
`default_nettype wire
